// File: rtl/hi5_pkg.sv
// Shared HI5 definitions: opcode values, default opcode width, the
// decoded stage-1 record and the load-unit FSM states.
package hi5_pkg;

  localparam int unsigned HI5_OPC_W     = 4;
  // Stage-1 record fields are sized for the widest supported build;
  // narrower builds zero-extend into them.
  localparam int unsigned HI5_OPC_MAX_W = 8;
  localparam int unsigned HI5_AW_MAX    = 16;
  localparam int unsigned HI5_IMM_MAX_W = 64;

  localparam int unsigned OPC_NOP    = 0;
  localparam int unsigned OPC_LOW    = 1;
  localparam int unsigned OPC_HIGH   = 2;
  localparam int unsigned OPC_LOWZ   = 3;
  localparam int unsigned OPC_LOWS   = 4;
  localparam int unsigned OPC_CLR    = 5;
  localparam int unsigned OPC_CLRALL = 15;

  typedef struct packed {
    logic                     valid;
    logic [HI5_OPC_MAX_W-1:0] opc;
    logic [HI5_AW_MAX-1:0]    addr;
    logic [HI5_IMM_MAX_W-1:0] imm;
  } hi5_s1_t;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } hi5_state_t;

endpackage

// File: rtl/hi5_regload_decode.sv
// Combinational HI5 opcode decode: write mask, write data, illegal-opcode
// flag and a CLRALL marker. The caller merges data into the old value
// under the mask.
module hi5_regload_decode
  import hi5_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IMM_W  = DATA_W / 2,
  parameter int unsigned OPC_W  = HI5_OPC_W
) (
  input  logic [OPC_W-1:0]  opc,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic              clrall
);

  localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'({IMM_W{1'b1}});

  // Opcode to mask/data; anything not listed is illegal and writes nothing
  always_comb begin
    mask   = '0;
    data   = '0;
    err    = 1'b0;
    clrall = 1'b0;
    case (opc)
      OPC_W'(OPC_NOP): begin
      end
      OPC_W'(OPC_LOW): begin
        mask = LOW_MASK;
        data = DATA_W'(imm);
      end
      OPC_W'(OPC_HIGH): begin
        mask = ~LOW_MASK;
        data = DATA_W'(imm) << IMM_W;
      end
      OPC_W'(OPC_LOWZ): begin
        mask = '1;
        data = DATA_W'(imm);
      end
      OPC_W'(OPC_LOWS): begin
        mask = '1;
        data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      end
      OPC_W'(OPC_CLR): begin
        mask = '1;
      end
      OPC_W'(OPC_CLRALL): begin
        mask   = '1;
        clrall = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/hi5_regload.sv
// HI5 immediate-load unit: two-stage accept/writeback into a register file
// with a synchronous write-first read port and a multi-cycle clear-all sweep.
// Define HI5_REGLOAD_TRACE_EN for a simulation trace of writebacks, errors
// and sweep start/end.
module hi5_regload
  import hi5_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned IMM_W   = DATA_W / 2,
  parameter int unsigned REGS    = 256,
  parameter int unsigned REG_AW  = $clog2(REGS),
  parameter int unsigned OPC_W   = HI5_OPC_W,
  parameter int unsigned INSTR_W = OPC_W + REG_AW + IMM_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_code,
  input  logic [REG_AW-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               retired,
  output logic               err,
  output logic [OPC_W-1:0]   err_code
);

  hi5_s1_t           s1;
  hi5_state_t        state, state_n;
  logic [REG_AW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] regs [REGS];

  logic              accept, accept_clrall;
  logic [OPC_W-1:0]  s1_opc;
  logic [REG_AW-1:0] s1_addr;
  logic [IMM_W-1:0]  s1_imm;
  logic [DATA_W-1:0] dec_mask, dec_data;
  logic              dec_err, dec_clrall;
  logic              s1_wr, sweep_wr, wen;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_cur, wb_val;
  logic              unused_s1;

  assign accept        = in_valid && in_ready;
  assign accept_clrall = accept && (in_code[INSTR_W-1 -: OPC_W] == OPC_W'(OPC_CLRALL));
  assign s1_opc        = s1.opc[OPC_W-1:0];
  assign s1_addr       = s1.addr[REG_AW-1:0];
  assign s1_imm        = s1.imm[IMM_W-1:0];
  assign unused_s1     = ^s1;

  hi5_regload_decode #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .OPC_W  (OPC_W)
  ) u_decode (
    .opc    (s1_opc),
    .imm    (s1_imm),
    .mask   (dec_mask),
    .data   (dec_data),
    .err    (dec_err),
    .clrall (dec_clrall)
  );

  // Stage 1: capture the accepted instruction fields
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
    end else begin
      s1.valid <= accept;
      if (accept) begin
        s1.opc  <= HI5_OPC_MAX_W'(in_code[INSTR_W-1 -: OPC_W]);
        s1.addr <= HI5_AW_MAX'(in_code[IMM_W +: REG_AW]);
        s1.imm  <= HI5_IMM_MAX_W'(in_code[IMM_W-1:0]);
      end
    end
  end

  // Writeback select: the sweep never overlaps a stage-2 instruction because
  // in_ready is low for its whole duration and cnt is 0 on the CLRALL's own edge
  always_comb begin
    s1_wr    = s1.valid && !dec_err;
    sweep_wr = (state == ST_SWEEP) && (cnt != '0);
    wen      = s1_wr || sweep_wr;
    wb_addr  = sweep_wr ? cnt : (dec_clrall ? '0 : s1_addr);
    wb_cur   = regs[wb_addr];
    wb_val   = sweep_wr ? '0 : ((wb_cur & ~dec_mask) | (dec_data & dec_mask));
  end

  // Register file write port (contents deliberately not reset)
  always_ff @(posedge clock) begin
    if (wen) regs[wb_addr] <= wb_val;
  end

  // Registered read with write-first forwarding
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= (wen && (wb_addr == rd_addr)) ? wb_val : regs[rd_addr];
    end
  end

  // Stage 2 status pulses; err_code holds until the next illegal opcode
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired  <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      retired <= s1.valid && !dec_err;
      err     <= s1.valid && dec_err;
      if (s1.valid && dec_err) err_code <= s1_opc;
    end
  end

  // FSM state, sweep counter and registered handshake/busy outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      busy     <= (state_n == ST_SWEEP);
      in_ready <= (state_n == ST_IDLE);
    end
  end

  // Next-state: sweep indices 1..REGS-1, counter wraps to 0 on exit
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept_clrall) state_n = ST_SWEEP;
      end
      ST_SWEEP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == REG_AW'(REGS - 1)) state_n = ST_IDLE;
      end
    endcase
  end

`ifdef HI5_REGLOAD_TRACE_EN
  // Simulation trace of writebacks, errors and sweep boundaries
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (s1.valid && dec_err)
        $display("%0t hi5_regload err opc=%0d addr=%0d", $time, s1_opc, s1_addr);
      if (wen)
        $display("%0t hi5_regload wb opc=%0d addr=%0d val=%h", $time,
                 sweep_wr ? OPC_W'(OPC_CLRALL) : s1_opc, wb_addr, wb_val);
      if (state == ST_IDLE && state_n == ST_SWEEP)
        $display("%0t hi5_regload sweep start", $time);
      if (state == ST_SWEEP && state_n == ST_IDLE)
        $display("%0t hi5_regload sweep end", $time);
    end
  end
`endif

endmodule

// File: tb/tb_hi5_regload.sv
// Scoreboard bench for hi5_regload (DATA_W=64, REGS=16): stimulus pushes
// expected retire/err events and read results; a monitor pops and compares.
module tb_hi5_regload;

  localparam int unsigned DW = 64;
  localparam int unsigned NR = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 4 + AW + DW / 2;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_code;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          retired;
  logic          err;
  logic [3:0]    err_code;

  hi5_regload #(
    .DATA_W (DW),
    .REGS   (NR),
    .OPC_W  (4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .retired  (retired),
    .err      (err),
    .err_code (err_code)
  );

  typedef struct {
    bit       is_err;
    bit [3:0] code;
  } ev_t;

  ev_t           evq [$];
  logic [DW-1:0] rdq [$];
  bit            rd_req;
  int            vectors;
  int            miscompares;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops expected events/reads whenever the DUT presents them
  initial begin
    bit req;
    ev_t e;
    logic [DW-1:0] exp_rd;
    forever begin
      @(posedge clock);
      req = rd_req;
      #1;
      if (retired || err) begin
        if (evq.size() == 0) begin
          chk("spurious retire/err", {62'd0, retired, err}, '0);
        end else begin
          e = evq.pop_front();
          chk("retired", DW'(retired), DW'(!e.is_err));
          chk("err", DW'(err), DW'(e.is_err));
          if (e.is_err) chk("err_code", DW'(err_code), DW'(e.code));
        end
      end
      if (req) begin
        exp_rd = rdq.pop_front();
        chk("rd_data", rd_data, exp_rd);
      end
    end
  end

  // All stimulus tasks start and end just after a falling edge
  task automatic send(input bit [3:0] opc, input bit [3:0] addr, input bit [31:0] imm,
                      input bit is_err);
    int unsigned guard = 0;
    in_valid = 1'b1;
    in_code  = {opc, addr, imm};
    evq.push_back('{is_err, opc});
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) chk("in_ready timeout", DW'(in_ready), 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_read(input bit [3:0] addr, input logic [DW-1:0] exp);
    rd_addr = addr;
    rd_req  = 1'b1;
    rdq.push_back(exp);
    @(negedge clock);
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned busy_cnt;
    int unsigned guard;
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    rd_addr  = '0;
    rd_req   = 1'b0;
    #1;
    chk("reset in_ready", DW'(in_ready), 0);
    chk("reset busy", DW'(busy), 0);
    chk("reset retired", DW'(retired), 0);
    chk("reset err", DW'(err), 0);
    chk("reset err_code", DW'(err_code), 0);
    chk("reset rd_data", rd_data, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk("in_ready before first edge", DW'(in_ready), 0);
    @(posedge clock);
    #1;
    chk("in_ready after first edge", DW'(in_ready), 1);
    @(negedge clock);

    // Half writes back to back, merge uses writeback-time contents
    send(4'd1, 4'd3, 32'h89AB_CDEF, 0);
    send(4'd2, 4'd3, 32'h0123_4567, 0);
    do_read(4'd3, 64'h0123_4567_89AB_CDEF);

    // Sign / zero extension, high half keeps low, clear, nop
    send(4'd4, 4'd7, 32'h8000_0001, 0);
    do_read(4'd7, 64'hFFFF_FFFF_8000_0001);
    send(4'd3, 4'd7, 32'h8000_0001, 0);
    do_read(4'd7, 64'h0000_0000_8000_0001);
    send(4'd2, 4'd7, 32'hCAFE_BABE, 0);
    do_read(4'd7, 64'hCAFE_BABE_8000_0001);
    send(4'd0, 4'd7, 32'h1111_1111, 0);
    do_read(4'd7, 64'hCAFE_BABE_8000_0001);
    send(4'd5, 4'd7, 32'h2222_2222, 0);
    do_read(4'd7, 64'h0);

    // Illegal opcode leaves target untouched
    send(4'd3, 4'd2, 32'h55, 0);
    send(4'd9, 4'd2, 32'hDEAD_BEEF, 1);
    do_read(4'd2, 64'h55);
    send(4'd14, 4'd4, 32'h1, 1);
    send(4'd1, 4'd2, 32'h66, 0);
    do_read(4'd2, 64'h66);
    chk("err_code held", DW'(err_code), 14);

    // Clear-all sweep with an instruction waiting behind it
    send(4'd15, 4'd9, 32'hFFFF_FFFF, 0);
    in_valid = 1'b1;
    in_code  = {4'd3, 4'd1, 32'h77};
    evq.push_back('{0, 4'd3});
    busy_cnt = 0;
    guard    = 0;
    while (busy && guard < 40) begin
      chk("in_ready low while busy", DW'(in_ready), 0);
      busy_cnt++;
      guard++;
      @(negedge clock);
    end
    chk("busy cycles", DW'(busy_cnt), 16);
    chk("in_ready after sweep", DW'(in_ready), 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) do_read(4'(i), (i == 1) ? 64'h77 : 64'h0);

    // Write-first forwarding on the writeback edge
    send(4'd1, 4'd5, 32'h1234, 0);
    do_read(4'd5, 64'h1234);

    // Reset during a sweep aborts it part way
    for (int i = 0; i < 16; i++) send(4'd3, 4'(i), 32'hA0 + i, 0);
    send(4'd15, 4'd0, 32'h0, 0);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort busy", DW'(busy), 0);
    chk("abort in_ready", DW'(in_ready), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) do_read(4'(i), (i < 4) ? 64'h0 : 64'hA0 + i);

    repeat (3) @(negedge clock);
    chk("event queue drained", DW'(evq.size()), 0);
    chk("read queue drained", DW'(rdq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
